tv_stream_checker: RTL and testbench
====================================

Name: tv_stream_checker

Overview:
- Synthesisable test-vector sequencer/checker for on-chip unit self-test.
- Streams packed vectors {stimulus, expected} from a synchronous vector RAM into a unit under test, one vector per cycle.
- Compares the unit's response against the expected field after a parametrised latency, and reports error count, first failing index and pass/fail.
- Generalises the per-module bench flow: vector widths, depth and unit latency are all parameters; adds an optional stop-on-first-error mode.

Parameters:
IN_W, 64, stimulus field width (bits)
OUT_W, 32, response/expected field width (bits)
ADDR_W, 7, vector RAM address width; max depth 2**ADDR_W
LAT, 1, unit-under-test latency in cycles from dut_valid to dut_out valid, 0..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled only in IDLE or DONE
vec_count  in  ADDR_W+1  number of vectors to run, sampled with start
stop_on_err  in  1  1 = abort on first mismatch, sampled with start
mem_rd_en  out  1  vector RAM read enable
mem_addr  out  ADDR_W  vector RAM read address
mem_rd_data  in  IN_W+OUT_W  RAM data {stim[MSBs], expected[OUT_W LSBs]}, valid 1 cycle after read
dut_in  out  IN_W  registered stimulus to unit
dut_valid  out  1  dut_in carries a vector this cycle
dut_out  in  OUT_W  unit response, valid LAT cycles after dut_valid
busy  out  1  run in progress
done  out  1  run complete; held until next start
pass  out  1  done and error_count==0
err_pulse  out  1  one-cycle strobe per mismatch
error_count  out  16  mismatch count, saturating
first_err_idx  out  ADDR_W  index of first mismatching vector

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0; expected pipeline and valid pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start=1:
  - Latch vec_count and stop_on_err; clear error_count, first_err_idx, done and pass.
  - vec_count==0: go to DONE next cycle with pass=1.
  - Otherwise: go to RUN.
- start while busy is ignored.
- RUN:
  - mem_rd_en=1 and mem_addr=k in the k-th RUN cycle (k=0..N-1), consecutive, no bubbles.
  - After the cycle issuing N-1, go to DRAIN.
- Datapath:
  - Edge after the read: dut_in <= stim field and dut_valid <= 1 (vector k drives dut_in in cycle k+1); the expected field enters a LAT-stage shift register, tagged with index k.
  - Compare dut_out with the expected value when the tagged valid emerges: cycle k+1+LAT. LAT=0 compares in the dut_valid cycle.
- Mismatch (dut_out != expected, full-width):
  - err_pulse=1 for that cycle.
  - error_count increments, saturating at 16'hFFFF.
  - If it is the first mismatch of the run, first_err_idx <= k.
- DRAIN: no reads; dut_valid follows the pipeline. Leave for DONE the cycle after the last compare (vector N-1). done/pass are registered: asserted in cycle N+2+LAT.
- stop_on_err=1, first mismatch:
  - Stop issuing reads immediately.
  - Clear all in-flight valid bits; in-flight vectors are not compared or counted.
  - Go to DONE next cycle; error_count=1.
- busy=1 in RUN and DRAIN only.
- dut_in holds its last value when dut_valid=0.
- vec_count > 2**ADDR_W saturates to 2**ADDR_W.

Test Plan:
- LAT=1, N=4, all vectors match, start at cycle -1:
  - mem_addr 0,1,2,3 in cycles 0..3; dut_valid cycles 1..4.
  - done=1, pass=1 at cycle 7; error_count=0.
- LAT=1, N=8, vectors 2 and 5 mismatch, stop_on_err=0:
  - err_pulse at cycles 4 and 7.
  - error_count=2, first_err_idx=2, pass=0 at done.
- Same vectors, stop_on_err=1:
  - Reads stop after the mismatch in cycle 4.
  - DONE next cycle with error_count=1, first_err_idx=2; vectors 3–4 are not counted.
- vec_count=0: done=1, pass=1 one cycle after start; no mem_rd_en pulses.
- rst_n low mid-RUN (N=16, cycle 6):
  - Immediate IDLE; all outputs 0.
  - A new start with N=2 then runs cleanly to pass=1.
- LAT=0 and LAT=15, N=2**ADDR_W, unit echoes expected:
  - pass=1; done at cycle N+2+LAT.
  - start pulsed during RUN is ignored.

Source files
------------

// File: rtl/tv_stream_checker.sv
// Test-vector sequencer/checker: streams {stim, expected} vectors from a synchronous RAM
// into a unit under test and compares its response after a fixed latency.
module tv_stream_checker #(
  parameter int IN_W   = 64,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 7,
  parameter int LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W:0]         vec_count,
  input  logic                    stop_on_err,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [IN_W+OUT_W-1:0]   mem_rd_data,
  output logic [IN_W-1:0]         dut_in,
  output logic                    dut_valid,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    err_pulse,
  output logic [15:0]             error_count,
  output logic [ADDR_W-1:0]       first_err_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   MAX_VEC = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ZERO_N  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_N   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_r, stateNext_s;
  logic [ADDR_W:0]     cnt_r;
  logic                stopOnErr_r;
  logic                rdEn_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                dutValid_r;
  logic [ADDR_W-1:0]   idxHead_r;
  logic [IN_W-1:0]     dutInHold_r;
  logic                done_r;
  logic                pass_r;
  logic [15:0]         errCnt_r;
  logic [ADDR_W-1:0]   firstIdx_r;

  logic [IN_W-1:0]     stim_s;
  logic [OUT_W-1:0]    expHead_s;
  logic                cmpValid_s;
  logic [OUT_W-1:0]    cmpExp_s;
  logic [ADDR_W-1:0]   cmpIdx_s;
  logic                pipeBusy_s;
  logic                mismatch_s;
  logic                abort_s;
  logic                launch_s;
  logic [ADDR_W:0]     nStart_s;
  logic                lastRead_s;
  logic                drainDone_s;
  logic                enterDone_s;
  logic [15:0]         errCntNext_s;

  assign stim_s      = mem_rd_data[IN_W+OUT_W-1:OUT_W];
  assign expHead_s   = mem_rd_data[OUT_W-1:0];
  assign mismatch_s  = cmpValid_s && (dut_out != cmpExp_s);
  assign abort_s     = mismatch_s && stopOnErr_r;
  assign launch_s    = start && ((state_r == IDLE) || (state_r == DONE));
  assign nStart_s    = (vec_count > MAX_VEC) ? MAX_VEC : vec_count;
  assign lastRead_s  = ({1'b0, addr_r} == (cnt_r - ONE_N));
  assign drainDone_s = !dutValid_r && !pipeBusy_s;
  assign enterDone_s = (stateNext_s == DONE) && ((state_r != DONE) || launch_s);

  // Expected values travel alongside the unit's latency, tagged with their vector index.
  if (LAT > 0) begin : gPipe
    logic [LAT-1:0]    pipeValid_r;
    logic [OUT_W-1:0]  pipeExp_r [LAT];
    logic [ADDR_W-1:0] pipeIdx_r [LAT];

    // Shift register for the expected field; an abort flushes every in-flight valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipeValid_r <= {LAT{1'b0}};
        for (int i = 0; i < LAT; i++) begin
          pipeExp_r[i] <= {OUT_W{1'b0}};
          pipeIdx_r[i] <= {ADDR_W{1'b0}};
        end
      end else begin
        pipeValid_r[0] <= dutValid_r && !abort_s;
        pipeExp_r[0]   <= expHead_s;
        pipeIdx_r[0]   <= idxHead_r;
        for (int i = 1; i < LAT; i++) begin
          pipeValid_r[i] <= pipeValid_r[i-1] && !abort_s;
          pipeExp_r[i]   <= pipeExp_r[i-1];
          pipeIdx_r[i]   <= pipeIdx_r[i-1];
        end
      end
    end

    assign cmpValid_s = pipeValid_r[LAT-1];
    assign cmpExp_s   = pipeExp_r[LAT-1];
    assign cmpIdx_s   = pipeIdx_r[LAT-1];
    assign pipeBusy_s = |pipeValid_r;
  end else begin : gNoPipe
    assign cmpValid_s = dutValid_r;
    assign cmpExp_s   = expHead_s;
    assign cmpIdx_s   = idxHead_r;
    assign pipeBusy_s = 1'b0;
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          stateNext_s = (nStart_s == ZERO_N) ? DONE : RUN;
        end else begin
          stateNext_s = state_r;
        end
      end
      RUN: begin
        if (abort_s) begin
          stateNext_s = DONE;
        end else if (lastRead_s) begin
          stateNext_s = DRAIN;
        end else begin
          stateNext_s = RUN;
        end
      end
      DRAIN: begin
        if (abort_s || drainDone_s) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = DRAIN;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Saturating mismatch counter, cleared by a new run.
  always_comb begin
    errCntNext_s = errCnt_r;
    if (launch_s) begin
      errCntNext_s = 16'h0000;
    end else if (mismatch_s && (errCnt_r != 16'hFFFF)) begin
      errCntNext_s = errCnt_r + 16'h0001;
    end else begin
      errCntNext_s = errCnt_r;
    end
  end

  // Sequencer state, read issue, stimulus launch and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= ZERO_N;
      stopOnErr_r <= 1'b0;
      rdEn_r      <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      dutValid_r  <= 1'b0;
      idxHead_r   <= {ADDR_W{1'b0}};
      dutInHold_r <= {IN_W{1'b0}};
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      errCnt_r    <= 16'h0000;
      firstIdx_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= stateNext_s;
      rdEn_r     <= (stateNext_s == RUN);
      dutValid_r <= rdEn_r && !abort_s;
      errCnt_r   <= errCntNext_s;

      if (launch_s) begin
        cnt_r       <= nStart_s;
        stopOnErr_r <= stop_on_err;
        addr_r      <= {ADDR_W{1'b0}};
      end else if ((state_r == RUN) && (stateNext_s == RUN)) begin
        addr_r <= addr_r + ONE_A;
      end

      if (rdEn_r) begin
        idxHead_r <= addr_r;
      end
      if (dutValid_r) begin
        dutInHold_r <= stim_s;
      end

      if (launch_s) begin
        firstIdx_r <= {ADDR_W{1'b0}};
      end else if (mismatch_s && (errCnt_r == 16'h0000)) begin
        firstIdx_r <= cmpIdx_s;
      end

      if (enterDone_s) begin
        done_r <= 1'b1;
        pass_r <= (errCntNext_s == 16'h0000);
      end else if (launch_s) begin
        done_r <= 1'b0;
        pass_r <= 1'b0;
      end
    end
  end

  // The RAM output register is the launch register; the hold register keeps dut_in stable between vectors.
  assign dut_in        = dutValid_r ? stim_s : dutInHold_r;
  assign dut_valid     = dutValid_r;
  assign mem_rd_en     = rdEn_r;
  assign mem_addr      = addr_r;
  assign busy          = (state_r == RUN) || (state_r == DRAIN);
  assign done          = done_r;
  assign pass          = pass_r;
  assign err_pulse     = mismatch_s;
  assign error_count   = errCnt_r;
  assign first_err_idx = firstIdx_r;

endmodule

// File: tb/tb_tv_stream_checker.sv
// Bench for tv_stream_checker: three instances (LAT 1, 0, 15) share a vector memory;
// each run is predicted from the vector contents and the unit's known response function.
module tb_tv_stream_checker;
  localparam int AW = 7;
  localparam int IW = 64;
  localparam int OW = 32;
  localparam int NI = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start       [NI];
  logic [AW:0]   vecCount    [NI];
  logic          stopOnErr   [NI];
  logic          memRdEn     [NI];
  logic [AW-1:0] memAddr     [NI];
  logic [IW+OW-1:0] memRdData[NI];
  logic [IW-1:0] dutIn       [NI];
  logic          dutValid    [NI];
  logic [OW-1:0] dutOut      [NI];
  logic          busy        [NI];
  logic          done        [NI];
  logic          pass        [NI];
  logic          errPulse    [NI];
  logic [15:0]   errCount    [NI];
  logic [AW-1:0] firstErrIdx [NI];

  logic [IW+OW-1:0] mem [DEPTH];
  int nCmp = 0;
  int nFail = 0;

  function automatic logic [OW-1:0] resp(input logic [IW-1:0] s);
    return s[31:0] ^ s[63:32] ^ 32'hA5C3_0F1E;
  endfunction

  function automatic int latOf(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 15);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gInst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    logic [IW+OW-1:0] rdq;

    tv_stream_checker #(.IN_W(IW), .OUT_W(OW), .ADDR_W(AW), .LAT(L)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .vec_count(vecCount[g]),
      .stop_on_err(stopOnErr[g]), .mem_rd_en(memRdEn[g]), .mem_addr(memAddr[g]),
      .mem_rd_data(memRdData[g]), .dut_in(dutIn[g]), .dut_valid(dutValid[g]),
      .dut_out(dutOut[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .err_pulse(errPulse[g]), .error_count(errCount[g]), .first_err_idx(firstErrIdx[g])
    );

    always @(posedge clk) if (memRdEn[g]) rdq <= mem[memAddr[g]];
    assign memRdData[g] = rdq;

    if (L == 0) begin : gUnit
      assign dutOut[g] = resp(dutIn[g]);
    end else begin : gUnit
      logic [OW-1:0] sh [L];
      always @(posedge clk) begin
        sh[0] <= resp(dutIn[g]);
        for (int i = 1; i < L; i++) sh[i] <= sh[i-1];
      end
      assign dutOut[g] = sh[L-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    nCmp++;
    assert (got === want) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic fillMem(input int b0, input int b1);
    for (int k = 0; k < DEPTH; k++) begin
      logic [IW-1:0] s;
      logic [OW-1:0] e;
      s = {$urandom(), $urandom()};
      e = resp(s);
      if (k == b0 || k == b1) e = e ^ (32'h0000_0001 << $urandom_range(0, 31));
      mem[k] = {s, e};
    end
  endtask

  task automatic chkIdle(input int g, input string tag);
    chk({tag, "_ctrl"}, {memRdEn[g], memAddr[g], dutValid[g], busy[g], done[g], pass[g],
                         errPulse[g], errCount[g], firstErrIdx[g]}, 64'd0);
    chk({tag, "_din"}, dutIn[g], 64'd0);
  endtask

  // Start a run at cycle -1 and check it against the expected outcome of the vector table.
  task automatic runTest(input int g, input int n, input bit stop, input int pulseAt, input string tag);
    int lat, nEff, a, expReads, expDone, expDv;
    int reads, dvCnt, busyCnt, doneCyc, addrBad, dinBad, cyc;
    int errs[$];
    int counted[$];
    int pulses[$];
    lat  = latOf(g);
    nEff = (n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < nEff; k++)
      if (mem[k][OW-1:0] != resp(mem[k][IW+OW-1:OW])) errs.push_back(k);
    if (stop && errs.size() > 0) begin
      a = errs[0] + 1 + lat;
      counted.push_back(errs[0]);
      expReads = (nEff - 1 < a) ? nEff : a + 1;
      expDone  = a + 1;
      expDv    = (a < nEff) ? a : nEff;
    end else begin
      counted  = errs;
      expReads = nEff;
      expDone  = (nEff == 0) ? 0 : nEff + 2 + lat;
      expDv    = nEff;
    end
    reads = 0; dvCnt = 0; busyCnt = 0; doneCyc = -1; addrBad = 0; dinBad = 0; cyc = 0;

    @(posedge clk); #1;
    start[g] = 1'b1; vecCount[g] = n[AW:0]; stopOnErr[g] = stop;
    @(posedge clk); #1;
    while (doneCyc < 0 && cyc < nEff + lat + 20) begin
      start[g] = (cyc == pulseAt);
      @(negedge clk);
      if (memRdEn[g]) begin
        if (memAddr[g] !== reads[AW-1:0]) addrBad++;
        reads++;
      end
      if (dutValid[g]) begin
        if (dvCnt >= DEPTH || dutIn[g] !== mem[dvCnt][IW+OW-1:OW]) dinBad++;
        dvCnt++;
      end
      if (errPulse[g]) pulses.push_back(cyc);
      if (busy[g]) busyCnt++;
      if (done[g]) doneCyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start[g] = 1'b0;

    chk({tag, "_done_cycle"}, doneCyc, expDone);
    chk({tag, "_reads"}, reads, expReads);
    chk({tag, "_addr_order"}, addrBad, 0);
    chk({tag, "_dut_valid"}, dvCnt, expDv);
    chk({tag, "_dut_in"}, dinBad, 0);
    chk({tag, "_busy_cycles"}, busyCnt, expDone);
    chk({tag, "_pulse_count"}, pulses.size(), counted.size());
    for (int i = 0; i < counted.size(); i++)
      chk({tag, "_pulse_cycle"}, (i < pulses.size()) ? pulses[i] : -1, counted[i] + 1 + lat);
    chk({tag, "_error_count"}, errCount[g], counted.size());
    chk({tag, "_first_err_idx"}, firstErrIdx[g], (counted.size() > 0) ? counted[0] : 0);
    chk({tag, "_pass"}, pass[g], (counted.size() == 0) ? 1 : 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0; vecCount[g] = '0; stopOnErr[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chkIdle(0, "rst0");
    chkIdle(1, "rst1");
    chkIdle(2, "rst2");
    @(negedge clk) rst_n = 1'b1;

    fillMem(-1, -1);
    runTest(0, 4, 1'b0, -1, "n4_match");

    fillMem(2, 5);
    runTest(0, 8, 1'b0, -1, "n8_errs");
    runTest(0, 8, 1'b1, -1, "n8_stop");
    runTest(0, 0, 1'b0, -1, "n0");

    for (int r = 0; r < 4; r++) begin
      fillMem($urandom_range(0, 25), $urandom_range(0, 40));
      runTest(0, $urandom_range(1, 40), 1'($urandom_range(0, 1)), -1, "rnd");
    end

    fillMem(-1, -1);
    @(posedge clk); #1;
    start[0] = 1'b1; vecCount[0] = 8'd16; stopOnErr[0] = 1'b0;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chkIdle(0, "mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    runTest(0, 2, 1'b0, -1, "after_rst");

    runTest(1, DEPTH, 1'b0, 5, "lat0_full");
    runTest(2, 200, 1'b0, 10, "lat15_sat");
    fillMem(126, -1);
    runTest(2, DEPTH, 1'b1, -1, "lat15_stop_drain");
    fillMem(40, 90);
    runTest(1, DEPTH, 1'b1, -1, "lat0_stop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
